pipe_issue: RTL and testbench
=============================

PIPE_ISSUE -- requirements
Module: pipe_issue

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; no other clock SHALL be used.
REQ-002 clk1  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream presents an instruction.
REQ-005 in_ready  output  1  queue can accept; combinational, equals NOT full.
REQ-006 in_rs1, in_rs2, in_rd  input  4 each  source and destination register indices.
REQ-007 in_func  input  2  operation code, passed through unchanged.
REQ-008 in_addr  input  8  memory address, passed through unchanged.
REQ-009 flush  input  1  discards all queued and in-flight tracking state.
REQ-010 rs1, rs2, rd  output  4 each  issued fields, registered, driving the pipeline ports of the same names.
REQ-011 func  output  2, addr  output  8  issued fields, registered.
REQ-012 issue_valid  output  1  high for exactly one cycle per issued instruction.
REQ-013 stall  output  1  registered; high while the head instruction is blocked by a hazard.
REQ-014 count  output  3  queue occupancy, 0..4.
REQ-015 issue_cnt  output  8  issued-instruction counter; wraps 255->0.
REQ-016 stall_cnt  output  8  hazard-stall cycle counter; saturates at 255.

Function
REQ-017 Queue: 4-entry FIFO of {rs1,rs2,rd,func,addr}; push when in_valid AND in_ready; order preserved.
REQ-018 Full (count=4): in_ready=0, in_valid ignored; a pop in the same cycle does not enable a push that cycle.
REQ-019 Empty (count=0): no issue; issue_valid=0; stall=0; stall_cnt unchanged.
REQ-020 Simultaneous push and pop when not full: count unchanged, both take effect.
REQ-021 Scoreboard: 3 slots S0..S2, each {v, rd}; every cycle S2<=S1, S1<=S0, S0<={issue, head.rd}, with v=0 on bubble cycles.
REQ-022 Hazard: head.rs1 or head.rs2 equals Si.rd for any Si with v=1.
REQ-023 Issue condition: count>0 AND NOT hazard AND NOT flush; on issue the head is popped, its fields are registered to the outputs, issue_valid<=1, and issue_cnt increments.
REQ-024 A consumer of a producer's rd issues no earlier than 4 cycles after the producer issues (3 bubble cycles).
REQ-025 An instruction whose rd matches its own rs1 or rs2 does not hazard against itself.
REQ-026 No issue: issue_valid<=0 and the field outputs hold their last values.
REQ-027 stall<=1 and stall_cnt increments (saturating) in every cycle with count>0 AND hazard.
REQ-028 flush: FIFO emptied, all Si.v cleared, issue_valid<=0, stall<=0, in the next cycle; counters keep their values; a push in the flush cycle is dropped.
REQ-029 The pipeline consumes the output fields when issue_valid=1; there is no backpressure from the pipeline.

Reset
REQ-030 On rst: count=0, all Si.v=0, issue_valid=0, stall=0, rs1=rs2=rd=0, func=0, addr=0, issue_cnt=0, stall_cnt=0.
REQ-031 rst overrides flush and in_valid; an instruction pushed or issuing in the rst cycle is discarded.
REQ-032 After rst deasserts, in_ready=1 in the same cycle and a push is accepted.

Verification
REQ-033 Independent stream: push (5,3,1,0,125), (6,4,2,1,126), (7,5,3,0,127), (8,6,4,1,128) on consecutive cycles -> issue_valid high on 4 consecutive cycles in order, stall never high, issue_cnt=4.
REQ-034 RAW: push (5,3,1,0,125), then (1,4,2,1,126) -> second issues exactly 4 cycles after the first, stall high for 3 cycles, stall_cnt=3.
REQ-035 Full: hold in_valid with 6 instructions, first dependent on a long chain -> in_ready drops at count=4, dropped pushes never issue, FIFO order kept.
REQ-036 Flush: with 3 queued and S0 valid, pulse flush -> count=0 next cycle, no issue; next push with rs1 = old rd issues without stall.
REQ-037 Reset mid-stall: assert rst while stall=1 -> all outputs at reset values next cycle; issue_cnt=0, stall_cnt=0.
REQ-038 Counter wrap: 256 independent issues -> issue_cnt returns to 0; 300 stall cycles -> stall_cnt=255.

Source files
------------

// File: rtl/pipe_issue.sv
// Single-issue stage: a 4-entry instruction FIFO whose head is released to the
// pipeline unless it reads a destination issued in any of the last three cycles.
module pipe_issue (
    input  logic       clk1,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_rs1,
    input  logic [3:0] in_rs2,
    input  logic [3:0] in_rd,
    input  logic [1:0] in_func,
    input  logic [7:0] in_addr,
    input  logic       flush,
    output logic [3:0] rs1,
    output logic [3:0] rs2,
    output logic [3:0] rd,
    output logic [1:0] func,
    output logic [7:0] addr,
    output logic       issue_valid,
    output logic       stall,
    output logic [2:0] count,
    output logic [7:0] issue_cnt,
    output logic [7:0] stall_cnt
);

    // Entry layout: {rs1[21:18], rs2[17:14], rd[13:10], func[9:8], addr[7:0]}
    logic [21:0] fifo_q [4];
    logic [21:0] fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  sb_v_q, sb_v_d;
    logic [3:0]  sb_rd_q [3];
    logic [3:0]  sb_rd_d [3];
    logic [21:0] out_q, out_d;
    logic        issue_valid_q, issue_valid_d;
    logic        stall_q, stall_d;
    logic [7:0]  issue_cnt_q, issue_cnt_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;

    logic [21:0] head;
    logic [3:0]  head_rs1, head_rs2, head_rd;
    logic        not_empty, hazard, do_issue, do_push;

    assign in_ready = (count_q != 3'd4);

    always_comb begin
        head      = fifo_q[rd_ptr_q];
        head_rs1  = head[21:18];
        head_rs2  = head[17:14];
        head_rd   = head[13:10];
        not_empty = (count_q != 3'd0);
        hazard    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb_v_q[i] && (sb_rd_q[i] == head_rs1 || sb_rd_q[i] == head_rs2)) begin
                hazard = 1'b1;
            end
        end
        do_issue = not_empty && !hazard && !flush;
        // Push is qualified by the pre-pop occupancy, so a full queue never
        // accepts even when the head leaves in the same cycle.
        do_push  = in_valid && in_ready && !flush;
    end

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_d         = out_q;
        issue_cnt_d   = issue_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        issue_valid_d = do_issue;
        stall_d       = not_empty && hazard && !flush;

        if (flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (do_push) begin
                fifo_d[wr_ptr_q] = {in_rs1, in_rs2, in_rd, in_func, in_addr};
                wr_ptr_d         = wr_ptr_q + 2'd1;
            end
            if (do_issue) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, do_push} - {2'b00, do_issue};
        end

        sb_v_d   = flush ? 3'b000 : {sb_v_q[1:0], do_issue};
        sb_rd_d[0] = head_rd;
        sb_rd_d[1] = sb_rd_q[0];
        sb_rd_d[2] = sb_rd_q[1];

        if (do_issue) begin
            out_d       = head;
            issue_cnt_d = issue_cnt_q + 8'd1;
        end
        if (stall_d && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                sb_rd_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            sb_v_q        <= '0;
            out_q         <= '0;
            issue_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            issue_cnt_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            fifo_q        <= fifo_d;
            sb_rd_q       <= sb_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            sb_v_q        <= sb_v_d;
            out_q         <= out_d;
            issue_valid_q <= issue_valid_d;
            stall_q       <= stall_d;
            issue_cnt_q   <= issue_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign rs1         = out_q[21:18];
    assign rs2         = out_q[17:14];
    assign rd          = out_q[13:10];
    assign func        = out_q[9:8];
    assign addr        = out_q[7:0];
    assign issue_valid = issue_valid_q;
    assign stall       = stall_q;
    assign count       = count_q;
    assign issue_cnt   = issue_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Bench for pipe_issue: directed scenarios plus random traffic, compared against
// a queue-and-issue-history model of the issue rules.
module tb_pipe_issue;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [1:0] func;
        logic [7:0] addr;
    } instr_t;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
    logic       in_ready, issue_valid, stall;
    logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [1:0] in_func = '0;
    logic [7:0] in_addr = '0;
    logic [3:0] rs1, rs2, rd;
    logic [1:0] func;
    logic [7:0] addr;
    logic [2:0] count;
    logic [7:0] issue_cnt, stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: pending instructions plus (cycle, rd) of recent issues
    instr_t     mq[$];
    int         hist_cyc[$];
    logic [3:0] hist_rd[$];
    instr_t     m_out = '0;
    logic       m_iv = 1'b0, m_stall = 1'b0;
    logic [7:0] m_issue_cnt = '0, m_stall_cnt = '0;

    pipe_issue dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
        .in_addr(in_addr), .flush(flush), .rs1(rs1), .rs2(rs2), .rd(rd),
        .func(func), .addr(addr), .issue_valid(issue_valid), .stall(stall),
        .count(count), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t mk(input int a, input int b, input int c, input int d, input int e);
        instr_t t;
        t.rs1  = 4'(a);
        t.rs2  = 4'(b);
        t.rd   = 4'(c);
        t.func = 2'(d);
        t.addr = 8'(e);
        return t;
    endfunction

    // A head may issue only if no instruction issued 1..3 cycles earlier wrote one of its sources.
    task automatic model_step(input logic v, input instr_t e, input logic fl, input logic r);
        int   cnt;
        logic hz;
        if (r) begin
            mq.delete();
            hist_cyc.delete();
            hist_rd.delete();
            m_out = '0; m_iv = 1'b0; m_stall = 1'b0;
            m_issue_cnt = '0; m_stall_cnt = '0;
        end else begin
            cnt = mq.size();
            hz  = 1'b0;
            if (cnt > 0) begin
                foreach (hist_cyc[i]) begin
                    if ((cyc - hist_cyc[i]) <= 3 && (mq[0].rs1 == hist_rd[i] || mq[0].rs2 == hist_rd[i]))
                        hz = 1'b1;
                end
            end
            if (fl) begin
                mq.delete();
                hist_cyc.delete();
                hist_rd.delete();
                m_iv = 1'b0; m_stall = 1'b0;
            end else begin
                if (cnt > 0 && !hz) begin
                    m_out = mq.pop_front();
                    m_iv  = 1'b1;
                    m_issue_cnt = m_issue_cnt + 8'd1;
                    hist_cyc.push_back(cyc);
                    hist_rd.push_back(m_out.rd);
                end else begin
                    m_iv = 1'b0;
                end
                m_stall = (cnt > 0) && hz;
                if (m_stall && m_stall_cnt != 8'hFF) m_stall_cnt = m_stall_cnt + 8'd1;
                if (v && cnt < 4) mq.push_back(e);
            end
        end
        cyc++;
        while (hist_cyc.size() > 0 && (cyc - hist_cyc[0]) > 3) begin
            void'(hist_cyc.pop_front());
            void'(hist_rd.pop_front());
        end
    endtask

    task automatic drive_cycle(input logic v, input instr_t e, input logic fl, input logic r);
        in_valid = v;
        in_rs1 = e.rs1; in_rs2 = e.rs2; in_rd = e.rd; in_func = e.func; in_addr = e.addr;
        flush = fl;
        rst = r;
        model_step(v, e, fl, r);
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, mk(1, 2, 3, 1, 99), 1'b1, 1'b1);
        drive_cycle(1'b1, mk(1, 2, 3, 1, 99), 1'b0, 1'b1);
        n_assert++;
        if ({issue_valid, stall, count, issue_cnt, stall_cnt} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_status: got iv=%b st=%b cnt=%0d ic=%0d sc=%0d, want all zero",
                     issue_valid, stall, count, issue_cnt, stall_cnt);
        end
        n_assert++;
        if ({rs1, rs2, rd, func, addr} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h, want 0", {rs1, rs2, rd, func, addr});
        end
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        drive_cycle(1'b1, mk(2, 2, 4, 0, 50), 1'b0, 1'b0);
        n_assert++;
        if (count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_first_push: count got %0d, want 1", count);
        end
        for (int k = 0; k < 6; k++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_independent();
        instr_t     s[4];
        logic [7:0] seen[$];
        int         first = -1, last = -1;
        logic       stalled = 1'b0;
        logic [7:0] c0;
        s[0] = mk(5, 3, 1, 0, 125); s[1] = mk(6, 4, 2, 1, 126);
        s[2] = mk(7, 5, 3, 0, 127); s[3] = mk(8, 6, 4, 1, 128);
        c0 = m_issue_cnt;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) drive_cycle(1'b1, s[k], 1'b0, 1'b0);
            else       drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL indep_status k=%0d: got iv=%b st=%b cnt=%0d ic=%0d sc=%0d, want iv=%b st=%b cnt=%0d ic=%0d sc=%0d",
                         k, issue_valid, stall, count, issue_cnt, stall_cnt,
                         m_iv, m_stall, mq.size(), m_issue_cnt, m_stall_cnt);
            end
            if (issue_valid === 1'b1) begin
                seen.push_back(addr);
                if (first < 0) first = k;
                last = k;
            end
            if (stall === 1'b1) stalled = 1'b1;
        end
        n_assert++;
        if (seen.size() != 4 || first != 1 || last != 4) begin
            n_fail++;
            $display("FAIL indep_timing: got %0d issues at k=%0d..%0d, want 4 at k=1..4", seen.size(), first, last);
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (i >= seen.size() || seen[i] !== 8'(125 + i)) begin
                n_fail++;
                $display("FAIL indep_order[%0d]: got addr %0d, want %0d", i, (i < seen.size()) ? seen[i] : 8'hxx, 125 + i);
            end
        end
        n_assert++;
        if (stalled) begin
            n_fail++;
            $display("FAIL indep_stall: got stall=1 somewhere, want never");
        end
        n_assert++;
        if (issue_cnt !== c0 + 8'd4) begin
            n_fail++;
            $display("FAIL indep_issue_cnt: got %0d, want %0d", issue_cnt, c0 + 8'd4);
        end
    endtask

    task automatic test_raw();
        int         t_iss[$];
        int         nstall = 0;
        logic [7:0] c0;
        c0 = m_stall_cnt;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      drive_cycle(1'b1, mk(5, 3, 1, 0, 125), 1'b0, 1'b0);
            else if (k == 1) drive_cycle(1'b1, mk(1, 4, 2, 1, 126), 1'b0, 1'b0);
            else             drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL raw_status k=%0d: got iv=%b st=%b cnt=%0d sc=%0d, want iv=%b st=%b cnt=%0d sc=%0d",
                         k, issue_valid, stall, count, stall_cnt, m_iv, m_stall, mq.size(), m_stall_cnt);
            end
            if (issue_valid === 1'b1) t_iss.push_back(k);
            if (stall === 1'b1) nstall++;
        end
        n_assert++;
        if (t_iss.size() != 2 || (t_iss[1] - t_iss[0]) != 4) begin
            n_fail++;
            $display("FAIL raw_spacing: got %0d issues, gap %0d, want 2 issues gap 4",
                     t_iss.size(), (t_iss.size() == 2) ? t_iss[1] - t_iss[0] : -1);
        end
        n_assert++;
        if (nstall != 3 || stall_cnt !== c0 + 8'd3) begin
            n_fail++;
            $display("FAIL raw_stall: got %0d stall cycles, stall_cnt %0d, want 3 and %0d", nstall, stall_cnt, c0 + 8'd3);
        end
    endtask

    task automatic test_full();
        instr_t     s[6];
        logic [7:0] seen[$];
        s[0] = mk(0, 0, 9, 0, 10);  s[1] = mk(9, 0, 10, 1, 11);
        s[2] = mk(10, 0, 11, 2, 12); s[3] = mk(11, 0, 12, 3, 13);
        s[4] = mk(12, 0, 13, 0, 14); s[5] = mk(13, 0, 14, 1, 15);
        for (int k = 0; k < 30; k++) begin
            n_assert++;
            if (in_ready !== (mq.size() < 4)) begin
                n_fail++;
                $display("FAIL full_in_ready k=%0d: got %b, want %b", k, in_ready, mq.size() < 4);
            end
            if (k == 5) begin
                n_assert++;
                if (in_ready !== 1'b0 || count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL full_drop_point: got in_ready=%b count=%0d, want 0 and 4", in_ready, count);
                end
            end
            if (k < 6) drive_cycle(1'b1, s[k], 1'b0, 1'b0);
            else       drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_assert++;
            if ({rs1, rs2, rd, func, addr} !== m_out) begin
                n_fail++;
                $display("FAIL full_fields k=%0d: got %h, want %h", k, {rs1, rs2, rd, func, addr}, m_out);
            end
            if (issue_valid === 1'b1) seen.push_back(addr);
        end
        n_assert++;
        if (seen.size() != 5) begin
            n_fail++;
            $display("FAIL full_issue_count: got %0d issues, want 5", seen.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_assert++;
            if (i >= seen.size() || seen[i] !== 8'(10 + i)) begin
                n_fail++;
                $display("FAIL full_order[%0d]: got addr %0d, want %0d", i, (i < seen.size()) ? seen[i] : 8'hxx, 10 + i);
            end
        end
    endtask

    task automatic test_flush();
        instr_t s[5];
        logic   stalled = 1'b0;
        s[0] = mk(0, 0, 7, 0, 20); s[1] = mk(7, 0, 8, 1, 21); s[2] = mk(7, 0, 9, 2, 22);
        s[3] = mk(7, 0, 10, 3, 23); s[4] = mk(7, 0, 11, 0, 24);
        for (int k = 0; k < 13; k++) begin
            if (k < 5)       drive_cycle(1'b1, s[k], 1'b0, 1'b0);
            else if (k == 6) drive_cycle(1'b1, mk(1, 1, 1, 1, 8'hEE), 1'b1, 1'b0);
            else if (k == 7) drive_cycle(1'b1, mk(8, 0, 12, 1, 25), 1'b0, 1'b0);
            else             drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL flush_status k=%0d: got iv=%b st=%b cnt=%0d, want iv=%b st=%b cnt=%0d",
                         k, issue_valid, stall, count, m_iv, m_stall, mq.size());
            end
            if (k == 6) begin
                n_assert++;
                if (count !== 3'd0 || issue_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_clear: got count=%0d iv=%b, want 0 and 0", count, issue_valid);
                end
            end
            if (k == 8) begin
                n_assert++;
                if (issue_valid !== 1'b1 || addr !== 8'd25) begin
                    n_fail++;
                    $display("FAIL flush_reissue: got iv=%b addr=%0d, want 1 and 25", issue_valid, addr);
                end
            end
            if (k >= 6 && stall === 1'b1) stalled = 1'b1;
        end
        n_assert++;
        if (stalled) begin
            n_fail++;
            $display("FAIL flush_no_stall: got stall=1 after flush, want never");
        end
    endtask

    task automatic test_random();
        instr_t e;
        logic   v, fl, r;
        for (int k = 0; k < 1500; k++) begin
            e  = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 255));
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 299) == 0);
            n_assert++;
            if (in_ready !== (mq.size() < 4)) begin
                n_fail++;
                $display("FAIL rand_in_ready k=%0d: got %b, want %b", k, in_ready, mq.size() < 4);
            end
            drive_cycle(v, e, fl, r);
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL rand_status k=%0d: got iv=%b st=%b cnt=%0d ic=%0d sc=%0d, want iv=%b st=%b cnt=%0d ic=%0d sc=%0d",
                         k, issue_valid, stall, count, issue_cnt, stall_cnt,
                         m_iv, m_stall, mq.size(), m_issue_cnt, m_stall_cnt);
            end
            n_assert++;
            if ({rs1, rs2, rd, func, addr} !== m_out) begin
                n_fail++;
                $display("FAIL rand_fields k=%0d: got %h, want %h", k, {rs1, rs2, rd, func, addr}, m_out);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        logic got = 1'b0;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, mk(0, 0, 3, 0, 30), 1'b0, 1'b0);
        drive_cycle(1'b1, mk(3, 0, 4, 1, 31), 1'b0, 1'b0);
        for (int k = 0; k < 10 && !got; k++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            if (stall === 1'b1) got = 1'b1;
        end
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL rstmid_wait_stall: got no stall within 10 cycles, want stall=1");
        end
        drive_cycle(1'b1, mk(5, 5, 5, 1, 77), 1'b1, 1'b1);
        n_assert++;
        if ({issue_valid, stall, count, issue_cnt, stall_cnt} !== 21'd0 || {rs1, rs2, rd, func, addr} !== 22'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got iv=%b st=%b cnt=%0d ic=%0d sc=%0d fields=%h, want all zero",
                     issue_valid, stall, count, issue_cnt, stall_cnt, {rs1, rs2, rd, func, addr});
        end
        n_assert++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_wrap();
        int     nissue = 0;
        int     j = 0;
        int     pre;
        instr_t e;
        for (int k = 0; k < 260; k++) begin
            if (k < 256) drive_cycle(1'b1, mk(0, 0, 1, k % 4, k), 1'b0, 1'b0);
            else         drive_cycle(1'b0, '0, 1'b0, 1'b0);
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL wrap_issue_status k=%0d: got iv=%b cnt=%0d ic=%0d, want iv=%b cnt=%0d ic=%0d",
                         k, issue_valid, count, issue_cnt, m_iv, mq.size(), m_issue_cnt);
            end
            if (issue_valid === 1'b1) nissue++;
        end
        n_assert++;
        if (nissue != 256 || issue_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_issue_cnt: got %0d issues, issue_cnt %0d, want 256 and 0", nissue, issue_cnt);
        end
        // 101-long dependency chain: every link costs three stall cycles
        for (int k = 0; k < 600 && !(j == 101 && mq.size() == 0); k++) begin
            e   = mk((j == 0) ? 0 : ((j - 1) % 2) + 1, 0, (j % 2) + 1, 0, j);
            pre = mq.size();
            drive_cycle(j < 101, e, 1'b0, 1'b0);
            if (j < 101 && pre < 4) j++;
            n_assert++;
            if ({issue_valid, stall, count, issue_cnt, stall_cnt} !==
                {m_iv, m_stall, 3'(mq.size()), m_issue_cnt, m_stall_cnt}) begin
                n_fail++;
                $display("FAIL wrap_stall_status k=%0d: got iv=%b st=%b cnt=%0d sc=%0d, want iv=%b st=%b cnt=%0d sc=%0d",
                         k, issue_valid, stall, count, stall_cnt, m_iv, m_stall, mq.size(), m_stall_cnt);
            end
        end
        n_assert++;
        if (j != 101 || stall_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_stall_cnt: got %0d pushed, stall_cnt %0d, want 101 and 255", j, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_full();
        test_flush();
        test_random();
        test_reset_mid_stall();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
